// File: rtl/interleaver_pkg.sv
// Shared constants and helpers for the ping-pong interleaver controller.
package interleaver_pkg;

    typedef enum logic {
        BANK0 = 1'b0,
        BANK1 = 1'b1
    } bank_t;

    localparam int PEND_W = 2;

    function automatic int block_len(input int row, input int col);
        return row * col;
    endfunction

    function automatic int cnt_width(input int row, input int col);
        return $clog2(row * col) + 1;
    endfunction

endpackage

// File: rtl/interleaver_axis_mux2.sv
// 2:1 AXI-Stream mux; only the selected source sees downstream ready.
module interleaver_axis_mux2
    import interleaver_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  bank_t            sel,
    input  logic             vld_en,
    input  logic             rdy_en,
    input  logic [WIDTH-1:0] a_tdata,
    input  logic             a_tvalid,
    input  logic             a_tlast,
    output logic             a_tready,
    input  logic [WIDTH-1:0] b_tdata,
    input  logic             b_tvalid,
    input  logic             b_tlast,
    output logic             b_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    output logic             m_tlast,
    input  logic             m_tready
);

    always_comb begin
        m_tdata  = a_tdata;
        m_tvalid = a_tvalid & vld_en;
        m_tlast  = a_tlast;
        a_tready = m_tready & rdy_en;
        b_tready = 1'b0;
        if (sel == BANK1) begin
            m_tdata  = b_tdata;
            m_tvalid = b_tvalid & vld_en;
            m_tlast  = b_tlast;
            a_tready = 1'b0;
            b_tready = m_tready & rdy_en;
        end
    end

endmodule

// File: rtl/interleaver_pingpong_ctrl.sv
// Ping-pong scheduler: alternates input blocks between two interleaver banks
// and drains whole blocks in arrival order through one output stream.
module interleaver_pingpong_ctrl
    import interleaver_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int ROW   = 512,
    parameter int COL   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [WIDTH-1:0]  m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic              bank_rst_n,
    output logic [WIDTH-1:0]  b0_s_tdata,
    output logic [WIDTH-1:0]  b1_s_tdata,
    output logic              b0_s_tvalid,
    output logic              b1_s_tvalid,
    input  logic              b0_s_tready,
    input  logic              b1_s_tready,
    input  logic [WIDTH-1:0]  b0_m_tdata,
    input  logic [WIDTH-1:0]  b1_m_tdata,
    input  logic              b0_m_tvalid,
    input  logic              b1_m_tvalid,
    input  logic              b0_m_tlast,
    input  logic              b1_m_tlast,
    output logic              b0_m_tready,
    output logic              b1_m_tready,
    output logic [PEND_W-1:0] pending,
    output logic              err
);

    localparam int LEN = block_len(ROW, COL);
    localparam int CW  = cnt_width(ROW, COL);
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    bank_t         wr_sel;
    bank_t         rd_sel;
    logic [CW-1:0] in_cnt;
    logic          arm;

    logic room;
    logic sel_s_ready;
    logic accept;
    logic blk_in;
    logic blk_out;
    logic sel_m_valid;
    logic oth_last;
    logic err_hit;

    assign b0_s_tdata = s_axis_tdata;
    assign b1_s_tdata = s_axis_tdata;

    assign room        = (pending != 2'd2);
    assign sel_s_ready = (wr_sel == BANK1) ? b1_s_tready : b0_s_tready;

    assign s_axis_tready = sel_s_ready & room & bank_rst_n;
    assign b0_s_tvalid   = s_axis_tvalid & (wr_sel == BANK0) & room & bank_rst_n;
    assign b1_s_tvalid   = s_axis_tvalid & (wr_sel == BANK1) & room & bank_rst_n;

    assign accept = s_axis_tvalid & s_axis_tready;
    assign blk_in = accept & (in_cnt == LAST);

    interleaver_axis_mux2 #(
        .WIDTH(WIDTH)
    ) u_out_mux (
        .sel      (rd_sel),
        .vld_en   (bank_rst_n & (pending != 2'd0)),
        .rdy_en   (bank_rst_n),
        .a_tdata  (b0_m_tdata),
        .a_tvalid (b0_m_tvalid),
        .a_tlast  (b0_m_tlast),
        .a_tready (b0_m_tready),
        .b_tdata  (b1_m_tdata),
        .b_tvalid (b1_m_tvalid),
        .b_tlast  (b1_m_tlast),
        .b_tready (b1_m_tready),
        .m_tdata  (m_axis_tdata),
        .m_tvalid (m_axis_tvalid),
        .m_tlast  (m_axis_tlast),
        .m_tready (m_axis_tready)
    );

    assign blk_out = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    // Protocol checks: banks talking out of turn, or occupancy over/underflow.
    assign sel_m_valid = (rd_sel == BANK1) ? b1_m_tvalid : b0_m_tvalid;
    assign oth_last    = (rd_sel == BANK1) ? (b0_m_tvalid & b0_m_tlast)
                                           : (b1_m_tvalid & b1_m_tlast);

    assign err_hit = bank_rst_n & (
          (sel_m_valid & (pending == 2'd0))
        | (oth_last & ~sel_m_valid & (pending != 2'd2))
        | (blk_in & ~blk_out & (pending == 2'd2))
        | (blk_out & ~blk_in & (pending == 2'd0)));

    // Banks stay in reset for one extra cycle after rst falls.
    always_ff @(posedge clk) begin
        if (rst) begin
            arm        <= 1'b0;
            bank_rst_n <= 1'b0;
        end else begin
            arm        <= 1'b1;
            bank_rst_n <= arm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sel <= BANK0;
            rd_sel <= BANK0;
            in_cnt <= '0;
        end else begin
            if (accept) begin
                in_cnt <= blk_in ? '0 : in_cnt + CW'(1);
            end
            if (blk_in) begin
                wr_sel <= bank_t'(~wr_sel);
            end
            if (blk_out) begin
                rd_sel <= bank_t'(~rd_sel);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            case ({blk_in, blk_out})
                2'b10: if (pending != 2'd2) pending <= pending + 2'd1;
                2'b01: if (pending != 2'd0) pending <= pending - 2'd1;
                default: pending <= pending;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (err_hit) begin
            err <= 1'b1;
        end
    end

endmodule
